hwlp_rou_pipe: RTL

Parametrised, pipelined successor of the HWLP reorder unit, located between the HWLP register file and the AGE address generators.
- For every AGE: selects one HWLP RF entry, reorders its IVs into subscript/IV slots, checks the IV constraint, and generates the PEA accumulation reset.
- Results are registered in a per-AGE output stage with valid/ready backpressure.
- Generalised over the current unit: the accumulation look-back distance is programmable, accumulation-init tracking is per AGE, and a synchronous clear is provided.

---
 rtl/hwlp_rou_pipe_if.sv | 52 +++++
 rtl/hwlp_rou_pipe.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/hwlp_rou_pipe_if.sv
// Bundle of the HWLP reorder unit signals between the HWLP RF / AGE side (master) and the unit (slave).
// With HWLP_ROU_PERF_CNT_EN defined, the per-AGE performance counter outputs are included.
interface hwlp_rou_pipe_if #(
  parameter int N_AGE    = 16,
  parameter int RF_SIZE  = 8,
  parameter int LOG2_RF  = $clog2(RF_SIZE),
  parameter int N_LP     = 4,
  parameter int LOG2_LP  = $clog2(N_LP + 1),
  parameter int NBIT_IV  = 8,
  parameter int N_SUB    = 2,
  parameter int N_IV_SUB = 2
);
  logic                                    clear_i;
  logic [N_AGE-1:0]                        age_active_i;
  logic [N_AGE*LOG2_RF-1:0]                sel_i;
  logic [RF_SIZE*N_LP*NBIT_IV-1:0]         rf_iv_i;
  logic [RF_SIZE-1:0]                      rf_valid_i;
  logic [RF_SIZE*N_LP-1:0]                 rf_endcond_i;
  logic [RF_SIZE-1:0]                      rf_end_i;
  logic [N_AGE*LOG2_LP-1:0]                cons_sel_i;
  logic [N_AGE*NBIT_IV-1:0]                cons_val_i;
  logic [N_AGE-1:0]                        acc_store_i;
  logic [LOG2_RF-1:0]                      acc_dist_i;
  logic [N_AGE-1:0]                        out_ready_i;
  logic [N_AGE-1:0]                        out_valid_o;
  logic [N_AGE*N_SUB*N_IV_SUB*NBIT_IV-1:0] out_iv_o;
  logic [N_AGE-1:0]                        out_end_o;
  logic [N_AGE-1:0]                        out_acc_reset_o;
  logic                                    stall_o;
`ifdef HWLP_ROU_PERF_CNT_EN
  logic [N_AGE*16-1:0]                     perf_beats_o;
  logic [N_AGE*16-1:0]                     perf_stalls_o;
`endif

  modport master (
`ifdef HWLP_ROU_PERF_CNT_EN
    input  perf_beats_o, perf_stalls_o,
`endif
    output clear_i, age_active_i, sel_i, rf_iv_i, rf_valid_i, rf_endcond_i, rf_end_i,
    output cons_sel_i, cons_val_i, acc_store_i, acc_dist_i, out_ready_i,
    input  out_valid_o, out_iv_o, out_end_o, out_acc_reset_o, stall_o
  );

  modport slave (
`ifdef HWLP_ROU_PERF_CNT_EN
    output perf_beats_o, perf_stalls_o,
`endif
    input  clear_i, age_active_i, sel_i, rf_iv_i, rf_valid_i, rf_endcond_i, rf_end_i,
    input  cons_sel_i, cons_val_i, acc_store_i, acc_dist_i, out_ready_i,
    output out_valid_o, out_iv_o, out_end_o, out_acc_reset_o, stall_o
  );
endinterface

// File: rtl/hwlp_rou_pipe.sv
// Pipelined HWLP reorder unit: per-AGE RF entry select, IV reorder, constraint check and PEA acc reset,
// registered behind a valid/ready stage. Optional per-AGE perf counters via HWLP_ROU_PERF_CNT_EN.
module hwlp_rou_pipe #(
  parameter int N_AGE    = 16,
  parameter int RF_SIZE  = 8,
  parameter int LOG2_RF  = $clog2(RF_SIZE),
  parameter int N_LP     = 4,
  parameter int LOG2_LP  = $clog2(N_LP + 1),
  parameter int NBIT_IV  = 8,
  parameter int N_SUB    = 2,
  parameter int N_IV_SUB = 2
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  hwlp_rou_pipe_if.slave  bus
);
  localparam int N_SLOT = N_SUB * N_IV_SUB;
  localparam int SLOT_W = N_SLOT * NBIT_IV;

  logic [NBIT_IV-1:0] w_iv   [RF_SIZE][N_LP];
  logic [N_LP-1:0]    w_endc [RF_SIZE];

  logic [N_AGE-1:0]        w_valid;
  logic [N_AGE-1:0]        w_end;
  logic [N_AGE-1:0]        w_acc;
  logic [N_AGE-1:0]        w_stall;
  logic [N_AGE*SLOT_W-1:0] w_out_iv;
`ifdef HWLP_ROU_PERF_CNT_EN
  logic [N_AGE*16-1:0]     w_beats;
  logic [N_AGE*16-1:0]     w_stalls;
`endif

  genvar gi, gj;

  for (gi = 0; gi < RF_SIZE; gi++) begin : g_rf
    assign w_endc[gi] = bus.rf_endcond_i[gi*N_LP +: N_LP];
    for (gj = 0; gj < N_LP; gj++) begin : g_lp
      assign w_iv[gi][gj] = bus.rf_iv_i[(gi*N_LP + gj)*NBIT_IV +: NBIT_IV];
    end
  end

  for (gi = 0; gi < N_AGE; gi++) begin : g_age
    logic [LOG2_RF-1:0] w_e;
    logic [LOG2_RF-1:0] w_lb;
    logic [LOG2_LP-1:0] w_cs;
    logic [NBIT_IV-1:0] w_cv;
    logic [SLOT_W-1:0]  w_slots;
    logic               w_ok;
    logic               w_rst_chk;
    logic               w_rst;
    logic               w_in_v;
    logic               w_load;
    logic               r_valid;
    logic               r_end;
    logic               r_acc;
    logic               r_init;
    logic [SLOT_W-1:0]  r_iv;

    assign w_e  = bus.sel_i[gi*LOG2_RF +: LOG2_RF];
    // RF_SIZE is a power of two, so the narrow subtraction wraps modulo RF_SIZE
    assign w_lb = w_e - bus.acc_dist_i;
    assign w_cs = bus.cons_sel_i[gi*LOG2_LP +: LOG2_LP];
    assign w_cv = bus.cons_val_i[gi*NBIT_IV +: NBIT_IV];

    for (gj = 0; gj < N_SLOT; gj++) begin : g_slot
      assign w_slots[gj*NBIT_IV +: NBIT_IV] = w_iv[w_e][gj];
    end

    // Selectors at or above N_LP mean "unconstrained"; the reset check then never fires
    always_comb begin
      w_ok      = 1'b1;
      w_rst_chk = 1'b0;
      if (w_cs < LOG2_LP'(N_LP)) begin
        w_rst_chk = 1'b1;
        for (int m = 0; m < N_LP; m++) begin
          if (LOG2_LP'(m) < w_cs) begin
            if (w_iv[w_e][m] != '0) w_ok = 1'b0;
            if (!w_endc[w_lb][m])   w_rst_chk = 1'b0;
          end else if (LOG2_LP'(m) == w_cs) begin
            if (w_iv[w_e][m] != w_cv) w_ok = 1'b0;
            if (w_iv[w_lb][m] != '0)  w_rst_chk = 1'b0;
          end
        end
      end
    end

    assign w_rst  = bus.acc_store_i[gi] & (r_init ? w_rst_chk : bus.rf_valid_i[w_lb]);
    assign w_in_v = bus.age_active_i[gi] & bus.rf_valid_i[w_e] & w_ok;
    assign w_load = ~r_valid | bus.out_ready_i[gi];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_valid <= 1'b0;
        r_end   <= 1'b0;
        r_acc   <= 1'b0;
        r_init  <= 1'b0;
        r_iv    <= '0;
      end else if (bus.clear_i) begin
        r_valid <= 1'b0;
        r_end   <= 1'b0;
        r_acc   <= 1'b0;
        r_init  <= 1'b0;
        r_iv    <= '0;
      end else if (!bus.age_active_i[gi]) begin
        // an inactive AGE drops any pending beat, regardless of ready
        r_valid <= 1'b0;
        r_end   <= 1'b0;
        r_acc   <= 1'b0;
        r_iv    <= '0;
      end else if (w_load) begin
        r_valid <= w_in_v;
        r_end   <= bus.rf_end_i[w_e];
        r_acc   <= w_in_v & w_rst;
        r_iv    <= w_in_v ? w_slots : '0;
        if (w_in_v & w_rst) r_init <= 1'b1;
      end
    end

    assign w_valid[gi]                   = r_valid;
    assign w_end[gi]                     = r_end;
    assign w_acc[gi]                     = r_acc;
    assign w_out_iv[gi*SLOT_W +: SLOT_W] = r_iv;
    assign w_stall[gi] = r_valid & ~bus.out_ready_i[gi] & bus.age_active_i[gi];

`ifdef HWLP_ROU_PERF_CNT_EN
    logic [15:0] r_beats;
    logic [15:0] r_stalls;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
        r_beats  <= '0;
        r_stalls <= '0;
      end else if (bus.clear_i) begin
        r_beats  <= '0;
        r_stalls <= '0;
      end else begin
        if (r_valid & bus.out_ready_i[gi] & ~&r_beats)   r_beats  <= r_beats + 16'd1;
        if (r_valid & ~bus.out_ready_i[gi] & ~&r_stalls) r_stalls <= r_stalls + 16'd1;
      end
    end

    assign w_beats[gi*16 +: 16]  = r_beats;
    assign w_stalls[gi*16 +: 16] = r_stalls;
`endif
  end

  assign bus.out_valid_o     = w_valid;
  assign bus.out_end_o       = w_end;
  assign bus.out_acc_reset_o = w_acc;
  assign bus.out_iv_o        = w_out_iv;
  assign bus.stall_o         = |w_stall;
`ifdef HWLP_ROU_PERF_CNT_EN
  assign bus.perf_beats_o    = w_beats;
  assign bus.perf_stalls_o   = w_stalls;
`endif
endmodule
